// File: rtl/fifo_test_pkg.sv
// fifo_test_pkg: FSM state encoding and status LED bit positions shared by the FIFO self-test controller
package fifo_test_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;
  localparam int LED_BUSY = 0;
  localparam int LED_PASS = 1;
  localparam int LED_FAIL = 2;
  localparam int LED_HB   = 3;
endpackage

// File: rtl/fifo_test_ctrl.sv
// fifo_test_ctrl: writes a counting burst into an external FIFO, reads it back, checks it and reports on LEDs
module fifo_test_ctrl
  import fifo_test_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int HB_W      = 24
) (
  input  logic              sys_clk_25M,
  input  logic              btn_n_rst,
  input  logic              start_test,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [3:0]        leds
);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] NUM  = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] INC  = CNT_W'(1);
  state_t           state;
  logic             start_q, rd_vld, start, miss;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, chk_cnt;
  logic [HB_W-1:0]  hb_cnt;
  assign start        = start_test & ~start_q;
  assign miss         = rd_vld & (fifo_rd_data != DATA_W'(chk_cnt));
  assign fifo_wr_en   = (state == ST_WRITE) & ~fifo_full;
  assign fifo_wr_data = DATA_W'(wr_cnt);
  assign fifo_rd_en   = (state == ST_READ) & ~fifo_empty & (rd_cnt < NUM);
  always_comb begin
    leds           = '0;
    leds[LED_BUSY] = state inside {ST_WRITE, ST_READ, ST_DRAIN};
    leds[LED_PASS] = state == ST_PASS;
    leds[LED_FAIL] = state == ST_FAIL;
    leds[LED_HB]   = hb_cnt[HB_W-1];
  end
  // a read-data mismatch is applied last so it overrides any same-cycle advance
  always_ff @(posedge sys_clk_25M or negedge btn_n_rst) begin
    if (!btn_n_rst) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      rd_vld  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      chk_cnt <= '0;
      hb_cnt  <= '0;
    end else begin
      start_q <= start_test;
      hb_cnt  <= hb_cnt + HB_W'(1);
      rd_vld  <= fifo_rd_en;
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL:
          if (start) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            chk_cnt <= '0;
            state   <= ST_WRITE;
          end
        ST_WRITE:
          if (fifo_full) state <= ST_FAIL;
          else begin
            wr_cnt <= wr_cnt + INC;
            if (wr_cnt == LAST) state <= ST_READ;
          end
        ST_READ: begin
          if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + INC;
            if (rd_cnt == LAST) state <= ST_DRAIN;
          end else if (fifo_empty) state <= ST_FAIL;
          if (rd_vld) begin
            if (miss) state <= ST_FAIL;
            else chk_cnt <= chk_cnt + INC;
          end
        end
        ST_DRAIN:
          if (rd_vld) begin
            state <= (miss | ~fifo_empty) ? ST_FAIL : ST_PASS;
            if (!miss) chk_cnt <= chk_cnt + INC;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_test_ctrl.sv
// tb_fifo_test_ctrl: runs fifo_test_ctrl against a behavioural FIFO model and checks outcome, strobes and LEDs
module tb_fifo_test_ctrl;
  logic       clk = 0, rst_n = 0, start_test = 0;
  logic       fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [7:0] fifo_wr_data, fifo_rd_data;
  logic [3:0] leds;
  int n_cmp = 0, n_err = 0;
  int depth_cfg = 16, corrupt_idx = 99, cnt = 0, rd_idx = 0, out_idx = 0, nxt = 0;
  logic out_vld = 0, model_clr = 0, mon_clr = 1;
  logic [7:0] q[$];
  logic [7:0] wr_log[$];
  int hb_ref = 0, hb_bad = 0, cyc = 0, n_rd = 0, vld_cyc = -1, fail_cyc = -1;

  typedef struct {
    int dep;
    int k;
    bit pass;
    int w;
    int r;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  fifo_test_ctrl #(.DATA_W(8), .NUM_WORDS(16), .HB_W(4)) dut (
    .sys_clk_25M (clk),
    .btn_n_rst   (rst_n),
    .start_test  (start_test),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full   (fifo_full),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .leds        (leds)
  );

  assign fifo_full  = cnt >= depth_cfg;
  assign fifo_empty = cnt == 0;

  // behavioural sync FIFO: one-cycle read latency, optional corruption of one read word
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || model_clr) begin
      q.delete();
      cnt          <= 0;
      fifo_rd_data <= '0;
      out_vld      <= 0;
      rd_idx = 0;
    end else begin
      nxt = cnt;
      out_vld <= 0;
      if (fifo_rd_en && cnt > 0) begin
        fifo_rd_data <= q.pop_front() ^ ((rd_idx == corrupt_idx) ? 8'h10 : 8'h00);
        out_idx <= rd_idx;
        out_vld <= 1;
        rd_idx++;
        nxt--;
      end
      if (fifo_wr_en && cnt < depth_cfg) begin
        q.push_back(fifo_wr_data);
        nxt++;
      end
      cnt <= nxt;
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) hb_ref <= 0;
    else hb_ref <= hb_ref + 1;

  always @(negedge clk) begin
    cyc++;
    if (leds[3] !== hb_ref[3]) hb_bad++;
    if (mon_clr) begin
      wr_log.delete();
      n_rd = 0;
      vld_cyc = -1;
      fail_cyc = -1;
    end else begin
      if (fifo_wr_en && !fifo_full) wr_log.push_back(fifo_wr_data);
      if (fifo_rd_en && !fifo_empty) n_rd++;
      if (out_vld && out_idx == corrupt_idx && vld_cyc < 0) vld_cyc = cyc;
      if (leds[2] && fail_cyc < 0) fail_cyc = cyc;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_model(int dep, int k, output bit p, output int w, output int r);
    if (dep < 16) begin
      p = 0; w = dep; r = 0;
    end else if (k < 16) begin
      p = 0; w = 16; r = (k + 2 > 16) ? 16 : k + 2;
    end else begin
      p = 1; w = 16; r = 16;
    end
  endfunction

  task automatic finish_check(string p, bit ep, int ew, int er, bit tim);
    int n = 0;
    while (!leds[0] && n < 8) begin @(negedge clk); #1; n++; end
    while (leds[0] && n < 100) begin @(negedge clk); #1; n++; end
    chk({p, "_done"}, leds[0], 0);
    if (ep) chk({p, "_latency_le_40"}, n <= 40, 1);
    repeat (4) begin @(negedge clk); #1; end
    chk({p, "_pass_led"}, leds[1], ep);
    chk({p, "_fail_led"}, leds[2], !ep);
    chk({p, "_writes"}, wr_log.size(), ew);
    chk({p, "_reads"}, n_rd, er);
    chk({p, "_idle_strobes"}, {fifo_wr_en, fifo_rd_en}, 0);
    for (int i = 0; i < wr_log.size(); i++) chk($sformatf("%s_wdata%0d", p, i), wr_log[i], i % 256);
    if (tim) chk({p, "_fail_cycle"}, fail_cyc, vld_cyc + 1);
  endtask

  task automatic setup(int dep, int k);
    depth_cfg = dep;
    corrupt_idx = k;
    start_test = 0;
    mon_clr = 1;
    @(posedge clk); #1 model_clr = 1;
    @(posedge clk); #1 model_clr = 0;
    @(negedge clk); #1 mon_clr = 0;
    start_test = 1;
  endtask

  task automatic run_test(string p, int dep, int k, bit ep, int ew, int er);
    setup(dep, k);
    finish_check(p, ep, ew, er, !ep && dep >= 16 && k < 16);
  endtask

  initial begin
    bit ep;
    int ew, er, dep, k, n;
    vecs[0] = '{16, 99, 1'b1, 16, 16};
    vecs[1] = '{16, 5, 1'b0, 16, 7};
    vecs[2] = '{8, 99, 1'b0, 8, 0};
    vecs[3] = '{16, 0, 1'b0, 16, 2};
    vecs[4] = '{16, 15, 1'b0, 16, 16};
    vecs[5] = '{20, 99, 1'b1, 16, 16};
    vecs[6] = '{16, 14, 1'b0, 16, 16};
    vecs[7] = '{15, 3, 1'b0, 15, 0};
    // power-on: reset with start already high, release counts as one start edge
    start_test = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("reset_leds", leds, 0);
    chk("reset_strobes", {fifo_wr_en, fifo_rd_en}, 0);
    rst_n = 1;
    mon_clr = 0;
    finish_check("poweron", 1, 16, 16, 0);
    for (int i = 0; i < 8; i++)
      run_test($sformatf("vec%0d", i), vecs[i].dep, vecs[i].k, vecs[i].pass, vecs[i].w, vecs[i].r);
    for (int i = 0; i < 8; i++) begin
      dep = $urandom_range(6, 20);
      k = $urandom_range(0, 24);
      ref_model(dep, k, ep, ew, er);
      run_test($sformatf("rand%0d_d%0d_k%0d", i, dep, k), dep, k, ep, ew, er);
    end
    // reset in the middle of the read phase, start held high through release
    setup(16, 99);
    n = 0;
    while (n_rd < 5 && n < 60) begin @(negedge clk); #1; n++; end
    chk("midrst_reads_before", n_rd, 5);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("midrst_strobes_now", {fifo_wr_en, fifo_rd_en}, 0);
    chk("midrst_leds_now", leds, 0);
    mon_clr = 1;
    repeat (3) begin @(negedge clk); #1; end
    chk("midrst_held_outputs", {leds, fifo_wr_en, fifo_rd_en}, 0);
    rst_n = 1;
    mon_clr = 0;
    finish_check("after_rst", 1, 16, 16, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("no_retrigger_leds", leds[2:0], 3'b010);
    chk("no_retrigger_writes", wr_log.size(), 16);
    run_test("second_pass", 16, 99, 1, 16, 16);
    chk("heartbeat_bad_cycles", hb_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
